// File: rtl/pf_xcvr_ref_clk_mon.sv
// Reference-clock monitor: per-channel toggle-rate measurement, tolerance qualification, preferred/failover select.
// Optional build macro REF_CLK_MON_REVERTIVE_EN: return to PREF_CH as soon as it requalifies.
module pf_xcvr_ref_clk_mon #(
  parameter int NUM_CH       = 2,
  parameter int WIN_CYCLES   = 4096,
  parameter int EXP_CNT      = 2048,
  parameter int TOL          = 16,
  parameter int GOOD_WINDOWS = 3,
  parameter int CNT_W        = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_CH-1:0]       REF_TGL_SYNC,
  input  logic [1:0]              PREF_CH,
  input  logic                    SEL_FORCE_EN,
  input  logic [1:0]              SEL_FORCE_CH,
  output logic [NUM_CH-1:0]       CH_VALID,
  output logic [1:0]              SEL_CH,
  output logic                    SEL_VALID,
  output logic                    SWITCH_PULSE,
  output logic [NUM_CH*CNT_W-1:0] MEAS_CNT,
  output logic                    MEAS_STB
);

  localparam int                     TMR_W    = $clog2(WIN_CYCLES);
  localparam logic [TMR_W-1:0]       TMR_LAST = TMR_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]       CNT_MAX  = '1;
  localparam logic signed [CNT_W:0]  EXP_S    = (CNT_W+1)'(EXP_CNT);
  localparam logic [CNT_W:0]         TOL_U    = (CNT_W+1)'(TOL);
  localparam logic [3:0]             GOOD_N   = 4'(GOOD_WINDOWS);

  typedef enum logic {S_NONE, S_LOCKED} sel_state_e;

  logic [NUM_CH-1:0]      prev_q;
  logic [TMR_W-1:0]       tmr_q;
  logic                   discard_q;
  logic [CNT_W-1:0]       cnt_q    [NUM_CH];
  logic [CNT_W-1:0]       meas_q   [NUM_CH];
  logic [3:0]             streak_q [NUM_CH];
  logic [NUM_CH-1:0]      ch_valid_q;
  logic                   stb_q;

  logic [NUM_CH-1:0]      tgl_edge;
  logic                   terminal;
  logic [CNT_W-1:0]       cnt_d    [NUM_CH];
  logic signed [CNT_W:0]  diff_s   [NUM_CH];
  logic [CNT_W:0]         mag      [NUM_CH];
  logic [3:0]             streak_d [NUM_CH];

  assign tgl_edge = REF_TGL_SYNC ^ prev_q;
  assign terminal = (tmr_q == TMR_LAST);

  // cnt_d already includes an edge seen on the terminal cycle, so it is the closing count.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch]    = (tgl_edge[ch] && (cnt_q[ch] != CNT_MAX)) ? cnt_q[ch] + 1'b1 : cnt_q[ch];
      diff_s[ch]   = $signed({1'b0, cnt_d[ch]}) - EXP_S;
      mag[ch]      = diff_s[ch][CNT_W] ? unsigned'(-diff_s[ch]) : unsigned'(diff_s[ch]);
      streak_d[ch] = (mag[ch] > TOL_U) ? 4'd0 :
                     (streak_q[ch] >= GOOD_N) ? streak_q[ch] : streak_q[ch] + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_q     <= '0;
      tmr_q      <= '0;
      discard_q  <= 1'b1;
      ch_valid_q <= '0;
      stb_q      <= 1'b0;
      // NOTE: the small per-channel arrays are reset explicitly; they are flops, not RAM.
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch]    <= '0;
        meas_q[ch]   <= '0;
        streak_q[ch] <= '0;
      end
    end else begin
      prev_q <= REF_TGL_SYNC;
      tmr_q  <= terminal ? '0 : tmr_q + 1'b1;
      stb_q  <= terminal && !discard_q;
      if (terminal) discard_q <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= terminal ? '0 : cnt_d[ch];
        if (terminal && !discard_q) begin
          meas_q[ch]     <= cnt_d[ch];
          streak_q[ch]   <= streak_d[ch];
          ch_valid_q[ch] <= (streak_d[ch] >= GOOD_N);
        end
      end
    end
  end

  // Selection works on a zero-padded 4-entry view so any 2-bit index is safe.
  logic [3:0]  valid4;
  logic        lo_any;
  logic [1:0]  lo_idx;
  logic [1:0]  nxt_ch;
  logic        nxt_valid;
  sel_state_e  state_q;
  logic [1:0]  sel_ch_q;
  logic        sel_valid_q;
  logic        switch_q;

  always_comb begin
    valid4               = '0;
    valid4[NUM_CH-1:0]   = ch_valid_q;
    lo_any               = 1'b0;
    lo_idx               = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (valid4[i]) begin
        lo_any = 1'b1;
        lo_idx = 2'(i);
      end
    end
  end

  always_comb begin
    nxt_ch    = sel_ch_q;
    nxt_valid = 1'b0;
    if (SEL_FORCE_EN) begin
      nxt_ch    = SEL_FORCE_CH;
      nxt_valid = valid4[SEL_FORCE_CH];
    end else if ((state_q == S_LOCKED) && valid4[sel_ch_q]) begin
      nxt_valid = 1'b1;
`ifdef REF_CLK_MON_REVERTIVE_EN
      if (valid4[PREF_CH] && (PREF_CH != sel_ch_q)) nxt_ch = PREF_CH;
`endif
    end else if (valid4[PREF_CH]) begin
      nxt_ch    = PREF_CH;
      nxt_valid = 1'b1;
    end else if (lo_any) begin
      nxt_ch    = lo_idx;
      nxt_valid = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_NONE;
      sel_ch_q    <= 2'd0;
      sel_valid_q <= 1'b0;
      switch_q    <= 1'b0;
    end else begin
      state_q     <= nxt_valid ? S_LOCKED : S_NONE;
      sel_ch_q    <= nxt_ch;
      sel_valid_q <= nxt_valid;
      switch_q    <= (nxt_ch != sel_ch_q) || (nxt_valid && !sel_valid_q);
    end
  end

  always_comb begin
    MEAS_CNT = '0;
    for (int ch = 0; ch < NUM_CH; ch++) MEAS_CNT[ch*CNT_W +: CNT_W] = meas_q[ch];
  end

  assign CH_VALID     = ch_valid_q;
  assign MEAS_STB     = stb_q;
  assign SEL_CH       = sel_ch_q;
  assign SEL_VALID    = sel_valid_q;
  assign SWITCH_PULSE = switch_q;

endmodule

// File: tb/tb_pf_xcvr_ref_clk_mon.sv
// Bench for pf_xcvr_ref_clk_mon: directed windows, scoreboarded measurements, selection/failover and reset checks.
module tb_pf_xcvr_ref_clk_mon;

  localparam int NUM_CH = 2;
  localparam int WIN    = 64;
  localparam int EXP    = 32;
  localparam int TOL    = 2;
  localparam int GOOD   = 3;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 5;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       ref_tgl = '0;
  logic [NUM_CH-1:0]       sat_tgl = '0;
  logic [1:0]              pref_ch = 2'd0;
  logic                    force_en = 1'b0;
  logic [1:0]              force_ch = 2'd0;

  logic [NUM_CH-1:0]       ch_valid;
  logic [1:0]              sel_ch;
  logic                    sel_valid, switch_pulse, meas_stb;
  logic [NUM_CH*CNT_W-1:0] meas_cnt;

  logic [NUM_CH-1:0]       sat_valid;
  logic [1:0]              sat_sel_ch;
  logic                    sat_sel_valid, sat_switch, sat_stb;
  logic [NUM_CH*SAT_W-1:0] sat_meas;

  always #5 clk = ~clk;

  pf_xcvr_ref_clk_mon #(
    .NUM_CH(NUM_CH), .WIN_CYCLES(WIN), .EXP_CNT(EXP), .TOL(TOL), .GOOD_WINDOWS(GOOD), .CNT_W(CNT_W)
  ) dut (
    .CLK(clk), .RESET(rst), .REF_TGL_SYNC(ref_tgl), .PREF_CH(pref_ch),
    .SEL_FORCE_EN(force_en), .SEL_FORCE_CH(force_ch),
    .CH_VALID(ch_valid), .SEL_CH(sel_ch), .SEL_VALID(sel_valid), .SWITCH_PULSE(switch_pulse),
    .MEAS_CNT(meas_cnt), .MEAS_STB(meas_stb)
  );

  pf_xcvr_ref_clk_mon #(
    .NUM_CH(NUM_CH), .WIN_CYCLES(WIN), .EXP_CNT(EXP), .TOL(TOL), .GOOD_WINDOWS(GOOD), .CNT_W(SAT_W)
  ) u_sat (
    .CLK(clk), .RESET(rst), .REF_TGL_SYNC(sat_tgl), .PREF_CH(pref_ch),
    .SEL_FORCE_EN(force_en), .SEL_FORCE_CH(force_ch),
    .CH_VALID(sat_valid), .SEL_CH(sat_sel_ch), .SEL_VALID(sat_sel_valid), .SWITCH_PULSE(sat_switch),
    .MEAS_CNT(sat_meas), .MEAS_STB(sat_stb)
  );

  typedef struct {
    int          cyc;
    logic [15:0] m0;
    logic [15:0] m1;
    logic [1:0]  v;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   sw_cnt      = 0;
  int   sw_last     = -1;
  int   streak [NUM_CH];
  logic sat_run     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic bres(input int n, input int j);
    return (((j + 1) * n) / WIN) != ((j * n) / WIN);
  endfunction

  // Observe the current cycle, then drive this cycle's input changes and advance one cycle.
  task automatic step(input logic [NUM_CH-1:0] tgl);
    exp_t e;
    if (switch_pulse === 1'b1) begin
      sw_cnt++;
      sw_last = cyc;
    end
    if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
      chk("meas_stb_missing", cyc, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    if (meas_stb !== 1'b0) begin
      if (sb_q.size() == 0) chk("meas_stb_unexpected", {31'd0, meas_stb}, 0);
      else begin
        e = sb_q.pop_front();
        chk("meas_stb_cycle", cyc, e.cyc);
        chk("meas_cnt_ch0", {16'd0, meas_cnt[15:0]}, {16'd0, e.m0});
        chk("meas_cnt_ch1", {16'd0, meas_cnt[31:16]}, {16'd0, e.m1});
        chk("ch_valid_at_stb", {30'd0, ch_valid}, {30'd0, e.v});
      end
    end
    ref_tgl = ref_tgl ^ tgl;
    if (sat_run) sat_tgl[0] = ~sat_tgl[0];
    @(negedge clk);
    cyc++;
  endtask

  // One full window with n0/n1 evenly spread edges; push the expected result unless it is a discard window.
  task automatic run_win(input int n0, input int n1, input bit push);
    exp_t e;
    int   n [NUM_CH];
    n[0] = n0;
    n[1] = n1;
    if (push) begin
      e.cyc = cyc + WIN;
      e.m0  = 16'(n0);
      e.m1  = 16'(n1);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (n[ch] >= EXP - TOL && n[ch] <= EXP + TOL) streak[ch] = (streak[ch] < GOOD) ? streak[ch] + 1 : streak[ch];
        else streak[ch] = 0;
        e.v[ch] = (streak[ch] >= GOOD);
      end
      sb_q.push_back(e);
    end
    for (int j = 0; j < WIN; j++) step({bres(n1, j), bres(n0, j)});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ch_valid"}, {30'd0, ch_valid}, 0);
    chk({tag, "_sel_ch"}, {30'd0, sel_ch}, 0);
    chk({tag, "_sel_valid"}, {31'd0, sel_valid}, 0);
    chk({tag, "_switch_pulse"}, {31'd0, switch_pulse}, 0);
    chk({tag, "_meas_cnt"}, meas_cnt, 0);
    chk({tag, "_meas_stb"}, {31'd0, meas_stb}, 0);
  endtask

  initial begin
    streak[0] = 0;
    streak[1] = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    cyc = 0;

    // Bring-up: discard window, then three good windows qualify both channels.
    run_win(32, 32, 1'b0);
    for (int w = 1; w <= 4; w++) run_win(32, 32, 1'b1);
    chk("bringup_ch_valid", {30'd0, ch_valid}, 3);
    chk("bringup_sel_ch", {30'd0, sel_ch}, 0);
    chk("bringup_sel_valid", {31'd0, sel_valid}, 1);
    chk("bringup_switch_count", sw_cnt, 1);
    chk("bringup_switch_cycle", sw_last, 257);

    // ch0 goes static: fail over to ch1 two cycles after the terminal cycle.
    run_win(0, 32, 1'b1);
    run_win(32, 32, 1'b1);
    chk("failover_sel_ch", {30'd0, sel_ch}, 1);
    chk("failover_sel_valid", {31'd0, sel_valid}, 1);
    chk("failover_switch_count", sw_cnt, 2);
    chk("failover_switch_cycle", sw_last, 385);

    // ch0 requalifies after three good windows.
    run_win(32, 32, 1'b1);
    run_win(32, 32, 1'b1);
    run_win(34, 32, 1'b1);
    chk("requal_ch_valid", {30'd0, ch_valid}, 3);
`ifdef REF_CLK_MON_REVERTIVE_EN
    chk("requal_sel_ch", {30'd0, sel_ch}, 0);
    chk("requal_switch_count", sw_cnt, 3);
    chk("requal_switch_cycle", sw_last, 577);
`else
    chk("requal_sel_ch", {30'd0, sel_ch}, 1);
    chk("requal_switch_count", sw_cnt, 2);
`endif

    // Tolerance edge: 34 edges kept the streak, 35 edges disqualifies ch0.
    run_win(35, 32, 1'b1);
    run_win(32, 32, 1'b1);
    chk("tol_ch_valid", {30'd0, ch_valid}, 2);
    chk("tol_sel_ch", {30'd0, sel_ch}, 1);
    chk("tol_sel_valid", {31'd0, sel_valid}, 1);
`ifdef REF_CLK_MON_REVERTIVE_EN
    chk("tol_switch_count", sw_cnt, 4);
    chk("tol_switch_cycle", sw_last, 705);
`else
    chk("tol_switch_count", sw_cnt, 2);
`endif

    // Reset at cycle 30 of a locked window.
    for (int j = 0; j < 30; j++) step({bres(32, j), bres(32, j)});
    rst     = 1'b1;
    ref_tgl = '0;
    step('0);
    chk_all_zero("midreset");
    rst       = 1'b0;
    cyc       = 0;
    streak[0] = 0;
    streak[1] = 0;
    sat_run   = 1'b1;
    run_win(32, 32, 1'b0);
    run_win(32, 32, 1'b1);

    // Saturating counter instance: 64 edges in a 5-bit counter.
    chk("sat_meas_stb", {31'd0, sat_stb}, 1);
    chk("sat_meas_ch0", {27'd0, sat_meas[4:0]}, 31);
    chk("sat_meas_ch1", {27'd0, sat_meas[9:5]}, 0);
    chk("sat_ch_valid0", {31'd0, sat_valid[0]}, 0);

    // Forced out-of-range channel.
    force_en = 1'b1;
    force_ch = 2'd3;
    step('0);
    chk("force_sel_ch", {30'd0, sel_ch}, 3);
    chk("force_sel_valid", {31'd0, sel_valid}, 0);
    chk("force_switch_pulse", {31'd0, switch_pulse}, 1);
    step('0);
    chk("force_switch_once", {31'd0, switch_pulse}, 0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pf_xcvr_ref_clk_mon.md
# pf_xcvr_ref_clk_mon

Multi-channel transceiver reference-clock monitor and selector for PolarFire designs. It measures the toggle rate of up to four pre-synchronised reference-clock toggle signals against the fabric clock over a fixed window, qualifies each channel against an expected count with tolerance, and selects one active reference with automatic failover. It sits beside the XCVR reference-clock buffers and drives the transceiver/PLL reference mux select and the status registers.

## Interface
Parameters:
- NUM_CH, 2: number of monitored channels (1..4).
- WIN_CYCLES, 4096: measurement window length in CLK cycles (≥ 8).
- EXP_CNT, 2048: expected edge count per window for a healthy channel.
- TOL, 16: allowed absolute deviation from EXP_CNT (inclusive).
- GOOD_WINDOWS, 3: consecutive good windows required to declare a channel valid (1..15).
- CNT_W, 16: edge-counter width.

Ports:
- CLK  in  1  fabric clock; all logic in this domain. One clock; reset is synchronous and active-high.
- RESET  in  1  synchronous, active-high reset.
- REF_TGL_SYNC  in  NUM_CH  per-channel divided reference toggle, already synchronised to CLK; each level change is one edge.
- PREF_CH  in  2  preferred channel index.
- SEL_FORCE_EN  in  1  manual selection override.
- SEL_FORCE_CH  in  2  forced channel index.
- CH_VALID  out  NUM_CH  per-channel qualified status.
- SEL_CH  out  2  selected channel index.
- SEL_VALID  out  1  selected channel is valid.
- SWITCH_PULSE  out  1  one-cycle pulse on selection change.
- MEAS_CNT  out  NUM_CH*CNT_W  last completed window count per channel, ch0 in LSBs.
- MEAS_STB  out  1  one-cycle pulse when MEAS_CNT/CH_VALID update.

## Operation
- Edge detect: prev register per channel (reset 0); edge = REF_TGL_SYNC ^ prev.
- Window timer counts 0..WIN_CYCLES-1 from the first cycle RESET is low, then wraps.
- Edge counters increment on edge, saturate at 2^CNT_W-1. An edge on the terminal cycle counts in the closing window; counters restart at 0 (or 1 if an edge occurs) on the following cycle.
- First window after reset is a discard window: no MEAS_STB, no qualification, MEAS_CNT stays 0.
- At each subsequent terminal: MEAS_CNT latched, MEAS_STB pulses. Channel good iff |cnt − EXP_CNT| ≤ TOL (computed at CNT_W+1 bits signed). Good increments a saturating streak; CH_VALID set when streak reaches GOOD_WINDOWS. A bad window clears streak and CH_VALID in the same update.
- Selection FSM, states NONE (SEL_VALID=0) and LOCKED (SEL_VALID=1), evaluated every cycle from registered CH_VALID:
  - SEL_FORCE_EN=1: SEL_CH=SEL_FORCE_CH; SEL_VALID=CH_VALID[SEL_FORCE_CH]; out-of-range index → SEL_VALID=0.
  - Else current channel valid: stay (see Configuration).
  - Else current invalid: PREF_CH if valid, else lowest-index valid channel → LOCKED; if none → NONE, SEL_CH holds.
- SWITCH_PULSE: SEL_CH changes, or SEL_VALID rises 0→1.
- Reset values: CH_VALID 0, SEL_CH 0, SEL_VALID 0, SWITCH_PULSE 0, MEAS_CNT 0, MEAS_STB 0; timer, streaks, counters 0.
- RESET mid-window: all state cleared immediately; a new discard window starts.

## Timing
- Edge counted one cycle after the input level change.
- Terminal cycle T → MEAS_STB, MEAS_CNT, CH_VALID update at T+1.
- SEL_CH, SEL_VALID, SWITCH_PULSE update at T+2 for qualification-driven changes; 1 cycle after any PREF_CH / SEL_FORCE_* change.
- First MEAS_STB at cycle 2*WIN_CYCLES after reset release.

## Configuration
- REF_CLK_MON_REVERTIVE_EN defined: in LOCKED on a non-preferred channel, switch to PREF_CH as soon as CH_VALID[PREF_CH]=1 (one SWITCH_PULSE).
- Not defined: non-revertive; stay on current channel while it is valid; PREF_CH used only when choosing after a failure or from NONE.

## Test plan
(NUM_CH=2, WIN_CYCLES=64, EXP_CNT=32, TOL=2, GOOD_WINDOWS=3, CNT_W=16)
- Both channels toggle every 2 cycles, PREF_CH=0 → MEAS_CNT=32/32 each window; CH_VALID=2'b11 at cycle 256; SEL_CH=0, SEL_VALID=1, single SWITCH_PULSE at cycle 257.
- Then hold ch0 static → next MEAS_CNT ch0=0, CH_VALID=2'b10; SEL_CH=1 with SWITCH_PULSE two cycles after terminal.
- Restore ch0 → after 3 good windows CH_VALID=2'b11; with macro SEL_CH returns to 0 with SWITCH_PULSE; without, SEL_CH stays 1.
- ch0 patterns giving 34 and 35 edges → 34 keeps streak; 35 clears CH_VALID[0] at that MEAS_STB.
- CNT_W=5, ch0 toggling every cycle (64 edges) → MEAS_CNT ch0=31, CH_VALID[0]=0.
- RESET asserted at cycle 30 of a valid-locked run → next cycle all outputs 0; next MEAS_STB exactly 128 cycles after RESET deasserts; SEL_FORCE_EN=1, SEL_FORCE_CH=3 → SEL_CH=3, SEL_VALID=0.
